// File: rtl/zelda_pkg.sv
// Shared types and constants for the draw-state pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zelda_pkg;

    // Write-port arbiter FSM states.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

    // Requester indices on the shared VGA write port.
    localparam int REQ_MAP     = 0;
    localparam int REQ_LINK    = 1;
    localparam int REQ_ENEMIES = 2;

    // Screen geometry and colour defaults (160x120, 3-bit colour).
    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_COLOR_W = 3;

    // Sprite colour key: pixels of this colour are never plotted for keyed requesters.
    localparam logic [DEF_COLOR_W-1:0] TRANSPARENT_COLOUR = 3'b101;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot winner among req, searching from ptr+1 upward (mod N).
// Latency: combinational.
// Backpressure: none; caller decides when to consume the winner and advance ptr.
//
// Ports:
//   req      - request vector
//   ptr      - index of the last owner
//   win      - one-hot winner (zero when req is zero)
//   win_idx  - binary index of the winner (0 when req is zero)
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [PTR_W-1:0] win_idx
);

    always_comb begin
        int   cand;
        logic found;
        win     = '0;
        win_idx = '0;
        cand    = 0;
        found   = 1'b0;
        // Offset 1 first so the last owner is checked last.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter write port among map/Link/enemy generators, one burst per grant.
// Latency: req->grant 1 cycle; accepted pixel->vga_* 1 cycle; >=1 idle cycle between bursts.
// Backpressure: none on pixels; losers simply hold req until they are granted.
//
// Ports:
//   clock, reset            - clock and async active-high reset
//   req/pix_valid/pix_last  - per-requester burst request and pixel strobes
//   pix_x/pix_y/pix_colour  - packed per-requester pixel data (slice i = requester i)
//   grant, burst_done, busy - ownership, end-of-burst pulse, port-in-use flag
//   vga_x/vga_y/vga_colour/vga_plot - registered adapter write port
module vga_write_arbiter
    import zelda_pkg::*;
#(
    parameter int                  NUM_REQ     = 3,
    parameter int                  X_W         = DEF_X_W,
    parameter int                  Y_W         = DEF_Y_W,
    parameter int                  COLOR_W     = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = TRANSPARENT_COLOUR,
    parameter logic [NUM_REQ-1:0]  KEY_MASK    = 3'b110
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         pix_valid,
    input  logic [NUM_REQ-1:0]         pix_last,
    input  logic [NUM_REQ*X_W-1:0]     pix_x,
    input  logic [NUM_REQ*Y_W-1:0]     pix_y,
    input  logic [NUM_REQ*COLOR_W-1:0] pix_colour,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         burst_done,
    output logic                       busy,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]         vga_colour,
    output logic                       vga_plot
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 plot_q, plot_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [COLOR_W-1:0]   col_q, col_d;

    logic [NUM_REQ-1:0]   win;
    logic [PTR_W-1:0]     win_idx;
    logic [COLOR_W-1:0]   owner_col;
    logic                 owner_keyed;

    rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // While granted, ptr_q holds the current owner's index, so it selects the data slice.
    assign owner_col   = pix_colour[ptr_q*COLOR_W +: COLOR_W];
    assign owner_keyed = KEY_MASK[ptr_q] && (owner_col == TRANSPARENT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        plot_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = win;
                    ptr_d   = win_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[ptr_q]) begin
                    // Abort wins over any pixel presented in the same cycle.
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (grant_q[ptr_q] && pix_valid[ptr_q]) begin
                    if (!owner_keyed) begin
                        plot_d = 1'b1;
                        x_d    = pix_x[ptr_q*X_W +: X_W];
                        y_d    = pix_y[ptr_q*Y_W +: Y_W];
                        col_d  = owner_col;
                    end
                    if (pix_last[ptr_q]) begin
                        done_d[ptr_q] = 1'b1;
                        grant_d       = '0;
                        state_d       = S_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    assign grant      = grant_q;
    assign burst_done = done_q;
    assign busy       = (state_q == S_GRANT);
    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;
    import zelda_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req, pix_valid, pix_last;
    logic [23:0] pix_x;
    logic [20:0] pix_y;
    logic [8:0]  pix_colour;
    logic [2:0]  grant, burst_done;
    logic        busy, vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int checks   = 0;
    int failures = 0;

    vga_write_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .grant      (grant),
        .burst_done (burst_done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] req, vld, lst;
        int         src;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [2:0] e_grant, e_done;
        logic       e_busy, e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [2:0] r, logic [2:0] v, logic [2:0] l, int s,
                                logic [7:0] x, logic [6:0] y, logic [2:0] c,
                                logic [2:0] eg, logic [2:0] ed, logic eb, logic ep,
                                logic [7:0] ex, logic [6:0] ey, logic [2:0] ec);
        vec_t t;
        t.req = r; t.vld = v; t.lst = l; t.src = s;
        t.x = x; t.y = y; t.c = c;
        t.e_grant = eg; t.e_done = ed; t.e_busy = eb; t.e_plot = ep;
        t.e_x = ex; t.e_y = ey; t.e_c = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Non-source slices carry distinctive junk so a wrong-slice select is visible.
    task automatic drive(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l,
                         input int s, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
        req        = r;
        pix_valid  = v;
        pix_last   = l;
        pix_x      = {3{8'd200}};
        pix_y      = {3{7'd100}};
        pix_colour = {3{3'b110}};
        pix_x[s*8 +: 8]      = x;
        pix_y[s*7 +: 7]      = y;
        pix_colour[s*3 +: 3] = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [2:0] eg, input logic [2:0] ed,
                           input logic eb, input logic ep);
        chk({nm, ".grant"}, 32'(grant), 32'(eg));
        chk({nm, ".burst_done"}, 32'(burst_done), 32'(ed));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
        chk({nm, ".vga_plot"}, 32'(vga_plot), 32'(ep));
    endtask

    initial begin
        // Map 3-pixel burst (map unkeyed, colour 101 plotted).
        vecs[0]  = mk(3'b001, 3'b000, 3'b000, 0,  0,  0, 3'd0, 3'b001, 3'b000, 1, 0,  0,  0, 3'd0);
        vecs[1]  = mk(3'b001, 3'b001, 3'b000, 0,  2,  3, 3'd5, 3'b001, 3'b000, 1, 1,  2,  3, 3'd5);
        vecs[2]  = mk(3'b001, 3'b001, 3'b000, 0,  3,  3, 3'd5, 3'b001, 3'b000, 1, 1,  3,  3, 3'd5);
        vecs[3]  = mk(3'b001, 3'b001, 3'b001, 0,  4,  3, 3'd5, 3'b000, 3'b001, 0, 1,  4,  3, 3'd5);
        vecs[4]  = mk(3'b000, 3'b000, 3'b000, 0,  0,  0, 3'd0, 3'b000, 3'b000, 0, 0,  4,  3, 3'd5);
        // Link keyed burst: 010,101,010 -> plot 1,0,1.
        vecs[5]  = mk(3'b010, 3'b000, 3'b000, 1,  0,  0, 3'd0, 3'b010, 3'b000, 1, 0,  4,  3, 3'd5);
        vecs[6]  = mk(3'b010, 3'b010, 3'b000, 1, 10, 20, 3'd2, 3'b010, 3'b000, 1, 1, 10, 20, 3'd2);
        vecs[7]  = mk(3'b010, 3'b010, 3'b000, 1, 11, 20, 3'd5, 3'b010, 3'b000, 1, 0, 10, 20, 3'd2);
        vecs[8]  = mk(3'b010, 3'b010, 3'b010, 1, 12, 20, 3'd2, 3'b000, 3'b010, 0, 1, 12, 20, 3'd2);
        vecs[9]  = mk(3'b000, 3'b000, 3'b000, 0,  0,  0, 3'd0, 3'b000, 3'b000, 0, 0, 12, 20, 3'd2);
        // Enemies present pixels while map owns the port; enemy grant follows map done.
        vecs[10] = mk(3'b001, 3'b000, 3'b000, 0,  0,  0, 3'd0, 3'b001, 3'b000, 1, 0, 12, 20, 3'd2);
        vecs[11] = mk(3'b101, 3'b101, 3'b000, 0, 30, 40, 3'd3, 3'b001, 3'b000, 1, 1, 30, 40, 3'd3);
        vecs[12] = mk(3'b101, 3'b101, 3'b001, 0, 31, 40, 3'd3, 3'b000, 3'b001, 0, 1, 31, 40, 3'd3);
        vecs[13] = mk(3'b100, 3'b100, 3'b000, 2, 51, 61, 3'd6, 3'b100, 3'b000, 1, 0, 31, 40, 3'd3);
        // Single-pixel enemy burst, transparent: accepted as last but not plotted.
        vecs[14] = mk(3'b100, 3'b100, 3'b100, 2, 50, 60, 3'd5, 3'b000, 3'b100, 0, 0, 31, 40, 3'd3);
        vecs[15] = mk(3'b000, 3'b000, 3'b000, 0,  0,  0, 3'd0, 3'b000, 3'b000, 0, 0, 31, 40, 3'd3);

        drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 3'd0);
        reset = 1'b1;
        tick();
        tick();
        chk_out("reset", 3'b000, 3'b000, 1'b0, 1'b0);
        chk("reset.vga_xyc", {vga_x, vga_y, vga_colour}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, vecs[i].vld, vecs[i].lst, vecs[i].src, vecs[i].x, vecs[i].y, vecs[i].c);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_done, vecs[i].e_busy, vecs[i].e_plot);
            chk($sformatf("vec%0d.vga_x", i), 32'(vga_x), 32'(vecs[i].e_x));
            chk($sformatf("vec%0d.vga_y", i), 32'(vga_y), 32'(vecs[i].e_y));
            chk($sformatf("vec%0d.vga_colour", i), 32'(vga_colour), 32'(vecs[i].e_c));
        end

        // Round robin with all three requesting: map, Link, enemies, map.
        begin
            int order[4] = '{0, 1, 2, 0};
            for (int b = 0; b < 4; b++) begin
                int o;
                o = order[b];
                drive(3'b111, 3'b000, 3'b000, 0, 0, 0, 3'd0);
                tick();
                chk_out($sformatf("rr%0d.grant", b), 3'(1 << o), 3'b000, 1'b1, 1'b0);
                drive(3'b111, 3'(1 << o), 3'b000, o, 8'(o * 10 + 1), 7'(o + 1), 3'(o + 1));
                tick();
                chk_out($sformatf("rr%0d.px0", b), 3'(1 << o), 3'b000, 1'b1, 1'b1);
                chk($sformatf("rr%0d.px0.vga_x", b), 32'(vga_x), 32'(o * 10 + 1));
                drive(3'b111, 3'(1 << o), 3'(1 << o), o, 8'(o * 10 + 2), 7'(o + 1), 3'(o + 1));
                tick();
                // The cycle right after the last edge is the mandatory idle gap.
                chk_out($sformatf("rr%0d.last", b), 3'b000, 3'(1 << o), 1'b0, 1'b1);
                chk($sformatf("rr%0d.last.vga_x", b), 32'(vga_x), 32'(o * 10 + 2));
            end
            drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 3'd0);
            tick();
            chk_out("rr.end", 3'b000, 3'b000, 1'b0, 1'b0);
        end

        // Link aborts after 2 of 5 pixels while map waits.
        drive(3'b011, 3'b000, 3'b000, 1, 0, 0, 3'd0);
        tick();
        chk_out("abort.grant", 3'b010, 3'b000, 1'b1, 1'b0);
        drive(3'b011, 3'b010, 3'b000, 1, 70, 7, 3'd2);
        tick();
        chk_out("abort.px0", 3'b010, 3'b000, 1'b1, 1'b1);
        drive(3'b011, 3'b010, 3'b000, 1, 71, 7, 3'd2);
        tick();
        chk_out("abort.px1", 3'b010, 3'b000, 1'b1, 1'b1);
        drive(3'b001, 3'b010, 3'b000, 1, 99, 99, 3'd2);
        tick();
        chk_out("abort.drop", 3'b000, 3'b000, 1'b0, 1'b0);
        chk("abort.drop.vga_x", 32'(vga_x), 32'd71);
        drive(3'b001, 3'b000, 3'b000, 0, 0, 0, 3'd0);
        tick();
        chk_out("abort.map_grant", 3'b001, 3'b000, 1'b1, 1'b0);
        drive(3'b001, 3'b001, 3'b001, 0, 5, 5, 3'd1);
        tick();
        chk_out("abort.map_done", 3'b000, 3'b001, 1'b0, 1'b1);
        drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 3'd0);
        tick();

        // Asynchronous reset in the middle of a Link burst.
        drive(3'b010, 3'b000, 3'b000, 1, 0, 0, 3'd0);
        tick();
        chk_out("rst.grant", 3'b010, 3'b000, 1'b1, 1'b0);
        drive(3'b010, 3'b010, 3'b000, 1, 80, 8, 3'd3);
        tick();
        chk_out("rst.px0", 3'b010, 3'b000, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_out("rst.async", 3'b000, 3'b000, 1'b0, 1'b0);
        chk("rst.async.vga_x", 32'(vga_x), 32'd0);
        #1 reset = 1'b0;
        drive(3'b111, 3'b000, 3'b000, 0, 0, 0, 3'd0);
        tick();
        chk_out("rst.map_first", 3'b001, 3'b000, 1'b1, 1'b0);
        drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 3'd0);
        tick();
        chk_out("rst.abort", 3'b000, 3'b000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
